// File: rtl/pacman_pkg.sv
// Shared types and constants for the PacMan motion block.
//   dir_t          : heading, encoding matches the dir output (0=UP 1=DOWN 2=LEFT 3=RIGHT)
//   req_t          : dir_t widened to 3 bits so the turn buffer can also hold REQ_NONE
//   motion_state_t : motion FSM states
//   reverse()      : opposite heading
//   decode_key()   : WASD HID keycode -> req_t
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef logic [2:0] req_t;
  localparam req_t REQ_NONE = 3'd4;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    FROZEN = 2'd2
  } motion_state_t;

  function automatic dir_t reverse(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  function automatic req_t decode_key(input logic [7:0] k);
    case (k)
      KEY_W:   return {1'b0, UP};
      KEY_S:   return {1'b0, DOWN};
      KEY_A:   return {1'b0, LEFT};
      KEY_D:   return {1'b0, RIGHT};
      default: return REQ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pacman_motion_if.sv
// Bundle between the motion block and its neighbours (keyboard source, game_logic).
//   master : drives keycode/win/lose, observes position
//   slave  : the motion block itself
//   keycode[7:0] HID keycode, win/lose from game_logic,
//   pX/pY[9:0] top-left position, pSize[9:0] sprite edge, dir heading, moving flag
interface pacman_motion_if;
  import pacman_pkg::*;

  logic [7:0] keycode;
  logic       win;
  logic       lose;
  logic [9:0] pX;
  logic [9:0] pY;
  logic [9:0] pSize;
  dir_t       dir;
  logic       moving;

  modport master (output keycode, win, lose,
                  input  pX, pY, pSize, dir, moving);
  modport slave  (input  keycode, win, lose,
                  output pX, pY, pSize, dir, moving);
endinterface

// File: rtl/pacman_motion_frame_tick_sync.sv
// Brings the asynchronous vsync strobe into the Clk domain and turns each rising
// edge into a registered one-cycle tick, three Clk edges after the rise.
//   Clk, Reset_n : system clock, async active-low reset
//   frame_clk    : vsync-rate strobe, asynchronous to Clk
//   tick         : 1-cycle pulse per frame_clk rise
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic sync1, sync2, sync3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      tick  <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/pacman_motion.sv
// PacMan position controller: decodes WASD into a buffered turn request, steps
// once per frame tick with clamping to the playfield, freezes on win/lose.
//   Clk, Reset_n : system clock, async active-low reset
//   frame_clk    : vsync strobe (async), synchronised internally
//   bus (slave)  : keycode/win/lose in; pX/pY/pSize/dir/moving out (all registered)
//
// state  | meaning
// IDLE   | parked at spawn, waiting for the first valid key
// MOVE   | stepping one STEP per tick, turns buffered until tile-aligned
// FROZEN | game over, position held until win/lose/key all clear
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 640,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 480,
  parameter int START_X = 304,
  parameter int START_Y = 240,
  parameter int SIZE    = 16,
  parameter int STEP    = 1,
  parameter int TILE    = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_clk,
  pacman_motion_if.slave  bus
);

  localparam logic signed [10:0] X_LO   = 11'(X_MIN);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [9:0]         TILE_M = 10'(TILE - 1);

  logic          tick;
  motion_state_t state;
  logic [9:0]    px_q, py_q;
  dir_t          dir_q;
  req_t          next_q;
  logic          moving_q;

  req_t              key_req;
  logic              aligned;
  dir_t              new_dir;
  req_t              req_after;
  logic signed [10:0] nx, ny, cx, cy;
  logic [9:0]        off_x, off_y;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign key_req = decode_key(bus.keycode);
  assign off_x   = px_q - 10'(X_MIN);
  assign off_y   = py_q - 10'(Y_MIN);
  assign aligned = ((off_x & TILE_M) == 10'd0) && ((off_y & TILE_M) == 10'd0);

  // Turn resolution followed by the step along the resulting heading.
  // A reverse is taken immediately; any other turn waits for tile alignment.
  always_comb begin
    new_dir   = dir_q;
    req_after = next_q;
    if (next_q != REQ_NONE && next_q[1:0] == reverse(dir_q)) begin
      new_dir   = dir_t'(next_q[1:0]);
      req_after = REQ_NONE;
    end else if (next_q != REQ_NONE && aligned) begin
      new_dir   = dir_t'(next_q[1:0]);
      req_after = REQ_NONE;
    end

    nx = $signed({1'b0, px_q});
    ny = $signed({1'b0, py_q});
    case (new_dir)
      UP:      ny = ny - STEP_S;
      DOWN:    ny = ny + STEP_S;
      LEFT:    nx = nx - STEP_S;
      default: nx = nx + STEP_S;
    endcase

    cx = nx;
    if (nx < X_LO)      cx = X_LO;
    else if (nx > X_HI) cx = X_HI;
    cy = ny;
    if (ny < Y_LO)      cy = Y_LO;
    else if (ny > Y_HI) cy = Y_HI;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      px_q     <= 10'(START_X);
      py_q     <= 10'(START_Y);
      dir_q    <= RIGHT;
      next_q   <= REQ_NONE;
      moving_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          px_q     <= 10'(START_X);
          py_q     <= 10'(START_Y);
          moving_q <= 1'b0;
          if (key_req != REQ_NONE) begin
            dir_q  <= dir_t'(key_req[1:0]);
            next_q <= REQ_NONE;
            state  <= MOVE;
          end
        end
        MOVE: begin
          if (bus.win || bus.lose) begin
            moving_q <= 1'b0;
            state    <= FROZEN;
          end else begin
            if (tick) begin
              dir_q    <= new_dir;
              px_q     <= cx[9:0];
              py_q     <= cy[9:0];
              moving_q <= (cx != $signed({1'b0, px_q})) || (cy != $signed({1'b0, py_q}));
              next_q   <= req_after;
            end
            // A key landing on the tick cycle is held for the following tick.
            if (key_req != REQ_NONE)
              next_q <= key_req;
          end
        end
        FROZEN: begin
          moving_q <= 1'b0;
          if (!bus.win && !bus.lose && bus.keycode == 8'h00)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pX     = px_q;
  assign bus.pY     = py_q;
  assign bus.pSize  = 10'(SIZE);
  assign bus.dir    = dir_q;
  assign bus.moving = moving_q;

endmodule

// File: tb/tb_pacman_motion.sv
module tb_pacman_motion;

  localparam int SX = 304, SY = 240;
  localparam int XHI = 624, YHI = 464;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;

  pacman_motion_if bus();

  pacman_motion dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct { int x; int y; int d; int mv; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // reference model: 0=idle 1=move 2=frozen; next -1 = none
  int m_state, m_x, m_y, m_dir, m_next, m_mov;

  function automatic int decode(input logic [7:0] k);
    case (k)
      8'h1A:   return 0;
      8'h16:   return 1;
      8'h04:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int rev(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input int exp);
    vectors++;
    if (act !== 16'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_now(input string nm, input int x, input int y, input int d, input int mv);
    cmp({nm, ".pX"}, {6'b0, bus.pX}, x);
    cmp({nm, ".pY"}, {6'b0, bus.pY}, y);
    cmp({nm, ".dir"}, {14'b0, bus.dir}, d);
    cmp({nm, ".moving"}, {15'b0, bus.moving}, mv);
  endtask

  task automatic model_reset();
    m_state = 0; m_x = SX; m_y = SY; m_dir = 3; m_next = -1; m_mov = 0;
  endtask

  task automatic model_key(input logic [7:0] k);
    int r;
    r = decode(k);
    if (r >= 0) begin
      if (m_state == 0) begin
        m_dir = r; m_next = -1; m_state = 1;
      end else if (m_state == 1) begin
        m_next = r;
      end
    end
  endtask

  task automatic model_tick();
    int nx, ny;
    exp_t e;
    if (m_state == 1) begin
      if (m_next >= 0 && m_next == rev(m_dir)) begin
        m_dir = m_next; m_next = -1;
      end else if (m_next >= 0 && (m_x % 16) == 0 && (m_y % 16) == 0) begin
        m_dir = m_next; m_next = -1;
      end
      nx = m_x; ny = m_y;
      case (m_dir)
        0: ny = ny - 1;
        1: ny = ny + 1;
        2: nx = nx - 1;
        default: nx = nx + 1;
      endcase
      if (nx < 0) nx = 0;
      if (nx > XHI) nx = XHI;
      if (ny < 0) ny = 0;
      if (ny > YHI) ny = YHI;
      m_mov = (nx != m_x || ny != m_y) ? 1 : 0;
      m_x = nx; m_y = ny;
    end else begin
      m_mov = 0;
    end
    e.x = m_x; e.y = m_y; e.d = m_dir; e.mv = m_mov;
    sb.push_back(e);
  endtask

  // game-over pulse away from any tick: MOVE -> FROZEN -> IDLE (spawn reloaded)
  task automatic model_end_pulse();
    if (m_state == 1) begin
      m_state = 0; m_x = SX; m_y = SY; m_mov = 0; m_next = -1;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic frame();
    @(negedge Clk);
    model_tick();
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge Clk);
    bus.keycode = k;
    model_key(k);
    @(negedge Clk);
    bus.keycode = 8'h00;
    @(negedge Clk);
  endtask

  task automatic end_pulse(input bit is_win);
    @(negedge Clk);
    if (is_win) bus.win = 1'b1; else bus.lose = 1'b1;
    @(negedge Clk);
    bus.win = 1'b0; bus.lose = 1'b0;
    model_end_pulse();
    repeat (3) @(negedge Clk);
  endtask

  // scoreboard monitor: one expected entry per frame_clk rise
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge frame_clk);
      repeat (4) @(posedge Clk);
      @(negedge Clk);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got frame with no expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        cmp("sb.pX", {6'b0, bus.pX}, e.x);
        cmp("sb.pY", {6'b0, bus.pY}, e.y);
        cmp("sb.dir", {14'b0, bus.dir}, e.d);
        cmp("sb.moving", {15'b0, bus.moving}, e.mv);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin : stim
    int r;
    logic [7:0] k;
    bus.keycode = 8'h00;
    bus.win = 1'b0;
    bus.lose = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_now("reset", SX, SY, 3, 0);
    cmp("reset.pSize", {6'b0, bus.pSize}, 16);
    Reset_n = 1'b1;
    @(negedge Clk);

    // 1: no key, 10 ticks
    repeat (10) frame();
    check_now("t1_idle", 304, 240, 3, 0);

    // 2: D then 4 ticks
    press(8'h07);
    repeat (4) frame();
    check_now("t2_right", 308, 240, 3, 1);

    // 3: buffered turn waits for tile alignment
    do_reset();
    press(8'h07);
    frame();
    check_now("t3_start", 305, 240, 3, 1);
    press(8'h1A);
    repeat (15) frame();
    check_now("t3_aligned", 320, 240, 3, 1);
    frame();
    check_now("t3_turn", 320, 239, 0, 1);

    // 4: reverse is immediate
    do_reset();
    press(8'h07);
    repeat (6) frame();
    press(8'h04);
    frame();
    check_now("t4_reverse", 309, 240, 2, 1);

    // 6: lose on the tick cycle -> no step, frozen, then back to spawn
    do_reset();
    press(8'h07);
    repeat (26) frame();
    check_now("t6_pre", 330, 240, 3, 1);
    begin
      exp_t e;
      @(negedge Clk);
      e.x = m_x; e.y = m_y; e.d = m_dir; e.mv = 0;
      sb.push_back(e);
      m_state = 2; m_mov = 0;
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      bus.lose = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      check_now("t6_frozen", 330, 240, 3, 0);
      bus.lose = 1'b0;
      @(negedge Clk);
      check_now("t6_release", 330, 240, 3, 0);
      @(negedge Clk);
      check_now("t6_respawn", 304, 240, 3, 0);
      model_reset();
      m_dir = 3;
    end
    frame();
    check_now("t6_idle_tick", 304, 240, 3, 0);

    // 5: right wall clamp
    do_reset();
    press(8'h07);
    repeat (319) frame();
    check_now("t5_623", 623, 240, 3, 1);
    frame();
    check_now("t5_624", 624, 240, 3, 1);
    frame();
    check_now("t5_wall", 624, 240, 3, 0);

    // 7: asynchronous reset between edges while moving
    press(8'h04);
    repeat (2) frame();
    check_now("t7_moving", 622, 240, 2, 1);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_now("t7_async_rst", SX, SY, 3, 0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 5) begin
        case ($urandom_range(0, 4))
          0: k = 8'h1A;
          1: k = 8'h16;
          2: k = 8'h04;
          3: k = 8'h07;
          default: k = 8'($urandom_range(0, 255));
        endcase
        press(k);
      end else if (r == 6) begin
        end_pulse(1'b0);
      end else if (r == 7) begin
        end_pulse(1'b1);
      end
      frame();
    end

    repeat (10) @(negedge Clk);
    cmp("sb_drained", 16'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
